// File: rtl/entropy_seq_ctrl.sv
// rtl/entropy_seq_ctrl.sv - ring-oscillator entropy source sequencer
// Drives clear -> warm-up -> sample-window sequences and reports status to the PIO.
module entropy_seq_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int WARM_W  = 8,
  parameter int WIN_W   = 16,
  parameter int EPOCH_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         out_port,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [WARM_W-1:0]  warmup_len,
  input  logic [WIN_W-1:0]   window_len,
  output logic [5:0]         in_port,
  output logic [NUM_CH-1:0]  ring_osc_enable,
  output logic [NUM_CH-1:0]  entropy_counter_enable,
  output logic               entropy_counter_clear,
  output logic               sample_valid,
  output logic [EPOCH_W-1:0] epoch
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WARMUP = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_start_q;
  logic               r_osc_force;
  logic               r_abort;
  logic               r_overrun;
  logic               r_sample_valid;
  logic [NUM_CH-1:0]  r_mask;
  logic [WARM_W-1:0]  r_warm;
  logic [WIN_W-1:0]   r_win;
  logic [WIN_W-1:0]   r_cnt;
  logic [WIN_W-1:0]   w_cnt_next;
  logic [WIN_W-1:0]   w_win_len;
  logic [EPOCH_W-1:0] r_epoch;
  logic               w_start_edge;
  logic               w_abort;
  logic               w_latch;
  logic               w_busy;
  logic               w_win_done;

  assign w_abort      = out_port[2];
  assign w_start_edge = out_port[1] & ~r_start_q;
  assign w_win_len    = (r_win == '0) ? WIN_W'(1) : r_win;
  assign w_busy       = (r_state == S_CLEAR) || (r_state == S_WARMUP) || (r_state == S_SAMPLE);
  assign w_win_done   = !w_abort && (r_state == S_SAMPLE) && (r_cnt <= WIN_W'(1));

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_latch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_next  = S_CLEAR;
          w_latch = 1'b1;
        end
      end
      S_CLEAR: begin
        if (r_warm != '0) begin
          w_next     = S_WARMUP;
          w_cnt_next = WIN_W'(r_warm);
        end else begin
          w_next     = S_SAMPLE;
          w_cnt_next = w_win_len;
        end
      end
      S_WARMUP: begin
        if (r_cnt <= WIN_W'(1)) begin
          w_next     = S_SAMPLE;
          w_cnt_next = w_win_len;
        end else begin
          w_cnt_next = r_cnt - WIN_W'(1);
        end
      end
      S_SAMPLE: begin
        if (r_cnt <= WIN_W'(1)) begin
          w_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - WIN_W'(1);
        end
      end
      S_DONE: begin
        if (out_port[3] || w_start_edge) begin
          w_next  = S_CLEAR;
          w_latch = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides any transition, including a start accepted this cycle.
    if (w_abort) begin
      w_next  = S_IDLE;
      w_latch = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_start_q      <= 1'b1;
      r_osc_force    <= 1'b0;
      r_abort        <= 1'b0;
      r_overrun      <= 1'b0;
      r_sample_valid <= 1'b0;
      r_mask         <= '0;
      r_warm         <= '0;
      r_win          <= '0;
      r_epoch        <= '0;
    end else begin
      r_state        <= w_next;
      r_cnt          <= w_cnt_next;
      r_start_q      <= out_port[1];
      r_osc_force    <= out_port[0];
      r_abort        <= w_abort;
      r_sample_valid <= w_win_done;
      if (w_win_done) begin
        r_epoch <= r_epoch + EPOCH_W'(1);
      end
      if (w_latch) begin
        r_mask <= ch_mask;
        r_warm <= warmup_len;
        r_win  <= window_len;
      end
      // A continuous re-entry into CLEAR is not an accepted start, so overrun survives it.
      if (w_abort || (w_latch && w_start_edge)) begin
        r_overrun <= 1'b0;
      end else if (w_busy && w_start_edge) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign ring_osc_enable        = r_abort ? '0 :
                                  (r_state == S_IDLE) ? {NUM_CH{r_osc_force}} :
                                  w_busy ? r_mask : '0;
  assign entropy_counter_enable = (!r_abort && (r_state == S_SAMPLE)) ? r_mask : '0;
  assign entropy_counter_clear  = r_abort || (r_state == S_CLEAR);
  assign sample_valid           = r_sample_valid;
  assign epoch                  = r_epoch;
  assign in_port                = {r_overrun, w_busy, (r_state == S_DONE), r_state};

endmodule

// File: tb/tb_entropy_seq_ctrl.sv
// tb/tb_entropy_seq_ctrl.sv - directed self-checking bench for entropy_seq_ctrl
module tb_entropy_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  out_port;
  logic [3:0]  ch_mask;
  logic [7:0]  warmup_len;
  logic [15:0] window_len;
  logic [5:0]  in_port;
  logic [3:0]  ring_osc_enable;
  logic [3:0]  entropy_counter_enable;
  logic        entropy_counter_clear;
  logic        sample_valid;
  logic [7:0]  epoch;

  int n_vec = 0;
  int n_miscompare = 0;

  entropy_seq_ctrl #(.NUM_CH(4), .WARM_W(8), .WIN_W(16), .EPOCH_W(8)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .out_port               (out_port),
    .ch_mask                (ch_mask),
    .warmup_len             (warmup_len),
    .window_len             (window_len),
    .in_port                (in_port),
    .ring_osc_enable        (ring_osc_enable),
    .entropy_counter_enable (entropy_counter_enable),
    .entropy_counter_clear  (entropy_counter_clear),
    .sample_valid           (sample_valid),
    .epoch                  (epoch)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_clr, n_osc, n_en, n_sv, sv_at, overlap, last, windows, bad;

  initial begin
    reset_n    = 1'b0;
    out_port   = 4'b0010;
    ch_mask    = 4'b0101;
    warmup_len = 8'd3;
    window_len = 16'd5;

    // Reset with start held high; releasing reset must not launch a sequence.
    tick();
    tick();
    check_eq("rst_in_port", 32'(in_port), 32'h0);
    check_eq("rst_osc", 32'(ring_osc_enable), 32'h0);
    check_eq("rst_clear", 32'(entropy_counter_clear), 32'h0);
    check_eq("rst_epoch", 32'(epoch), 32'h0);
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    check_eq("post_rst_in_port", 32'(in_port), 32'h0);
    out_port = 4'b0000;
    tick();

    // Basic one-shot: W=3, N=5.
    out_port = 4'b0010;
    tick();
    check_eq("t2_clear_state", 32'(in_port), 32'h11);
    n_clr = 0; n_osc = 0; n_en = 0; n_sv = 0; sv_at = -1; overlap = 0;
    for (int c = 0; c < 20; c++) begin
      if (entropy_counter_clear) n_clr++;
      if (ring_osc_enable == 4'b0101 && !entropy_counter_clear) n_osc++;
      if (entropy_counter_enable == 4'b0101) n_en++;
      if (entropy_counter_clear && entropy_counter_enable != 4'b0) overlap++;
      if (sample_valid) begin
        n_sv++;
        sv_at = c;
      end
      if (c == 0) out_port = 4'b0000;
      tick();
    end
    check_eq("t2_clear_cycles", 32'(n_clr), 32'd1);
    check_eq("t2_osc_cycles", 32'(n_osc), 32'd8);
    check_eq("t2_en_cycles", 32'(n_en), 32'd5);
    check_eq("t2_clr_en_overlap", 32'(overlap), 32'd0);
    check_eq("t2_sv_count", 32'(n_sv), 32'd1);
    check_eq("t2_sv_cycle", 32'(sv_at), 32'd9);
    check_eq("t2_epoch", 32'(epoch), 32'd1);
    check_eq("t2_in_port_done", 32'(in_port), 32'h0C);
    check_eq("t2_osc_done", 32'(ring_osc_enable), 32'h0);

    // Zero lengths: CLEAR, one SAMPLE cycle, then DONE.
    warmup_len = 8'd0;
    window_len = 16'd0;
    out_port   = 4'b0010;
    tick();
    check_eq("t3_state_clear", 32'(in_port[2:0]), 32'd1);
    out_port = 4'b0000;
    tick();
    check_eq("t3_state_sample", 32'(in_port[2:0]), 32'd3);
    check_eq("t3_en", 32'(entropy_counter_enable), 32'h5);
    tick();
    check_eq("t3_state_done", 32'(in_port[2:0]), 32'd4);
    check_eq("t3_sv", 32'(sample_valid), 32'd1);
    check_eq("t3_epoch", 32'(epoch), 32'd2);

    // Start edge during SAMPLE sets overrun and leaves the window length alone.
    warmup_len = 8'd2;
    window_len = 16'd6;
    out_port   = 4'b0010;
    tick();
    n_en = 0; n_sv = 0; sv_at = -1;
    for (int c = 0; c < 15; c++) begin
      if (entropy_counter_enable == 4'b0101) n_en++;
      if (sample_valid) begin
        n_sv++;
        sv_at = c;
      end
      if (c == 5) begin
        check_eq("t5_overrun_set", 32'(in_port[5]), 32'd1);
        out_port = 4'b0000;
      end
      if (c == 0) out_port = 4'b0000;
      if (c == 4) begin
        out_port   = 4'b0010;
        window_len = 16'd1;
      end
      tick();
    end
    check_eq("t5_en_cycles", 32'(n_en), 32'd6);
    check_eq("t5_sv_cycle", 32'(sv_at), 32'd9);
    check_eq("t5_done_in_port", 32'(in_port), 32'h2C);
    check_eq("t5_epoch", 32'(epoch), 32'd3);

    // Next accepted start clears overrun.
    window_len = 16'd6;
    out_port   = 4'b0010;
    tick();
    check_eq("t5_overrun_cleared", 32'(in_port), 32'h11);
    out_port = 4'b0000;
    tick();
    tick();
    tick();
    tick();
    check_eq("t6_pre_abort_en", 32'(entropy_counter_enable), 32'h5);

    // Abort for 3 cycles mid-SAMPLE, with osc_force high to show it is ignored.
    out_port = 4'b0101;
    n_clr = 0; n_en = 0; n_osc = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (entropy_counter_clear) n_clr++;
      if (entropy_counter_enable != 4'b0) n_en++;
      if (ring_osc_enable != 4'b0) n_osc++;
      if (in_port != 6'h0) n_osc++;
    end
    out_port = 4'b0001;
    check_eq("t6_abort_clear_cycles", 32'(n_clr), 32'd3);
    check_eq("t6_abort_en_cycles", 32'(n_en), 32'd0);
    check_eq("t6_abort_osc_status", 32'(n_osc), 32'd0);
    tick();
    check_eq("t6_idle_clear", 32'(entropy_counter_clear), 32'd0);
    check_eq("t6_idle_force", 32'(ring_osc_enable), 32'hF);
    check_eq("t6_idle_in_port", 32'(in_port), 32'h0);
    n_sv = 0;
    for (int c = 0; c < 15; c++) begin
      if (sample_valid) n_sv++;
      tick();
    end
    check_eq("t6_no_sv", 32'(n_sv), 32'd0);
    check_eq("t6_epoch_kept", 32'(epoch), 32'd3);

    // Asynchronous reset mid-window drops outputs without waiting for a clock.
    out_port = 4'b0000;
    tick();
    out_port = 4'b0010;
    tick();
    out_port = 4'b0000;
    tick();
    tick();
    tick();
    tick();
    check_eq("t7_sampling", 32'(entropy_counter_enable), 32'h5);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t7_async_en", 32'(entropy_counter_enable), 32'h0);
    check_eq("t7_async_osc", 32'(ring_osc_enable), 32'h0);
    check_eq("t7_async_in_port", 32'(in_port), 32'h0);
    tick();
    reset_n = 1'b1;

    // Continuous: W=2, N=4 gives an 8-cycle period; 300 windows wrap epoch to 44.
    warmup_len = 8'd2;
    window_len = 16'd4;
    out_port   = 4'b1000;
    tick();
    out_port = 4'b1010;
    tick();
    out_port = 4'b1000;
    windows = 0; last = 0; bad = 0;
    for (int c = 1; c < 2600; c++) begin
      tick();
      if (sample_valid) begin
        windows++;
        if (windows == 1) check_eq("t4_first_done", 32'(c), 32'd7);
        else if (c - last != 8) bad++;
        last = c;
        if (windows == 256) check_eq("t4_epoch_wrap", 32'(epoch), 32'd0);
        if (windows == 300) begin
          check_eq("t4_epoch_300", 32'(epoch), 32'd44);
          out_port = 4'b0000;
          break;
        end
      end
    end
    check_eq("t4_windows", 32'(windows), 32'd300);
    check_eq("t4_bad_periods", 32'(bad), 32'd0);
    tick();
    check_eq("t4_done_holds", 32'(in_port[2:0]), 32'd4);
    check_eq("t4_sv_single", 32'(sample_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule

// File: doc/entropy_seq_ctrl.md
# entropy_seq_ctrl

Parametrised sequencer for the ring-oscillator entropy source. It turns the HPS PIO control word into timed enable and clear strobes for up to NUM_CH ring oscillators and their entropy counters, and returns a status word to the PIO input port. It replaces static bit-splitting of the PIO with a clear -> warm-up -> sample-window sequence, one-shot or continuous, plus a window-complete strobe and an epoch count for software.

## Interface
- NUM_CH, 4: number of ring-oscillator/counter channels (1..32)
- WARM_W, 8: width of warm-up length input
- WIN_W, 16: width of sample-window length input
- EPOCH_W, 8: width of completed-window counter
- clk  in  1  single clock for all logic
- reset_n  in  1  reset, asynchronous, active-low
- out_port  in  4  PIO control: [0] osc_force, [1] start, [2] abort, [3] continuous
- ch_mask  in  NUM_CH  channels to run; latched on start
- warmup_len  in  WARM_W  warm-up cycles, oscillators on and counters off; latched on start
- window_len  in  WIN_W  sample cycles, 0 treated as 1; latched on start
- in_port  out  6  status: [2:0] state code, [3] done, [4] busy, [5] overrun
- ring_osc_enable  out  NUM_CH  per-channel oscillator enable
- entropy_counter_enable  out  NUM_CH  per-channel counter enable
- entropy_counter_clear  out  1  counter clear, shared by all channels
- sample_valid  out  1  one-cycle strobe marking that counter values are final
- epoch  out  EPOCH_W  completed windows, wraps modulo 2^EPOCH_W

## Operation
- All outputs are registered and decoded from the state and latched values. No input-to-output combinational path exists.
- Start edge: start_edge = out_port[1] & ~start_q. start_q resets to 1, so a start held high through reset does not fire.
- States and codes:
  - IDLE(0)
    - ring_osc_enable = {NUM_CH{osc_force}}. Legacy manual mode; osc_force is registered.
    - Counters disabled, clear low.
    - start_edge latches mask/lengths, clears overrun, then goes to CLEAR.
  - CLEAR(1)
    - entropy_counter_clear = 1 for exactly one cycle; oscillators = mask.
    - Next state is WARMUP if the latched warmup_len is non-zero, else SAMPLE.
  - WARMUP(2)
    - Oscillators = mask, counters off; lasts warmup_len cycles, then SAMPLE.
  - SAMPLE(3)
    - Oscillators and counters = mask; lasts max(window_len,1) cycles, then DONE.
  - DONE(4)
    - All enables 0, so counts freeze. done = 1.
    - sample_valid pulses in the first DONE cycle and epoch increments in the same cycle.
    - If continuous = 1 (sampled each DONE cycle), next state is CLEAR, re-latching ch_mask/lengths.
    - Otherwise DONE holds until start_edge, then goes to CLEAR.
- busy = 1 in CLEAR, WARMUP and SAMPLE. done = 1 only in DONE.
- overrun: a sticky flag, set by a start_edge in CLEAR, WARMUP or SAMPLE; the edge is otherwise ignored. It is cleared by an accepted start or by abort.
- abort (level) has priority over everything:
  - Next state is IDLE.
  - While abort is high: entropy_counter_clear = 1, all counter enables 0, oscillators 0 (osc_force ignored).
  - overrun is cleared. epoch is not reset.
- The phase counter is WIN_W bits wide (≥ WARM_W), loaded on each phase entry and decremented to 1. It never wraps.

## Timing
- Reset values: state IDLE, every output 0, in_port = 0, epoch 0, overrun 0.
- Start rises before edge k:
  - CLEAR occupies cycle k (clear high).
  - WARMUP occupies k+1 .. k+W (W = warmup_len).
  - SAMPLE occupies the next N cycles (N = max(window_len,1)).
  - DONE begins at k+1+W+N, with sample_valid high in that cycle only.
- Counter enable is high for exactly N cycles per window. Clear and enable are never high in the same cycle.
- In continuous mode, DONE lasts 1 cycle, so the period is 2+W+N cycles.
- Abort sampled at edge j: outputs show IDLE/abort values from cycle j. When abort drops, IDLE resumes the following cycle. Any in-flight window is lost: no sample_valid, no epoch increment.
- Abort and start_edge in the same cycle: abort wins and the start is discarded.
- Asynchronous reset mid-window: all outputs drop immediately. The next sequence needs a fresh start edge.

## Test plan
- Reset with out_port = 4'b0010 held high, then release -> state stays IDLE; in_port = 0.
- ch_mask = 4'b0101, warmup_len = 3, window_len = 5, start pulse -> clear for 1 cycle, osc = 0101 for 8 cycles, counter enable = 0101 for exactly 5 cycles, sample_valid once, epoch = 1, in_port[3] = 1.
- window_len = 0, warmup_len = 0 -> CLEAR then 1 SAMPLE cycle, then DONE; total of 2 cycles from start to DONE.
- Continuous = 1, W = 2, N = 4, run 300 windows -> period of 8 cycles each; epoch wraps 255 -> 0 -> 44.
- Start edge during SAMPLE -> in_port[5] = 1 and the window length is unchanged; the next accepted start clears it.
- Abort asserted mid-SAMPLE for 3 cycles -> enables 0 and clear high for 3 cycles, then IDLE; no sample_valid; epoch unchanged.
